// File: rtl/gpu_instruction_encoder.sv
// gpu_instruction_encoder
// Issue-side counterpart of the GPU instruction decoder. It takes one complete
// draw request per valid/ready handshake and turns it into the ordered command
// stream the decoder expects:
//   set-point-1 (op 1), set-point-2 (op 2) or set-radius (op 3), then the draw.
// Shadow copies of the last point/radius sent let redundant set commands be
// skipped.
//
// Ports
//   clk, n_rst               clock, asynchronous active-low reset
//   req_valid_i/req_ready_o  request handshake
//   req_opcode_i             4=line, 5=rect, 6=circle, 7=arc
//   req_x1/y1/x2/y2_i        endpoints
//   req_rad_i, req_oct_i     radius, arc octant
//   req_r/g/b_i              colour
//   shadow_inv_i             downstream lost its state: forget the shadows
//   opcode_o, parameters_o   command being offered
//   command_o, cmd_ready_i   command handshake (backpressure via cmd_ready_i)
//   busy_o                   a request is being serialised
//   err_o                    one-cycle pulse after accepting an unsupported opcode
module gpu_instruction_encoder #(
  parameter int WIDTH_BITS   = 10,
  parameter int HEIGHT_BITS  = 9,
  parameter int CHANNEL_BITS = 8
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic [3:0]              req_opcode_i,
  input  logic [WIDTH_BITS-1:0]   req_x1_i,
  input  logic [WIDTH_BITS-1:0]   req_x2_i,
  input  logic [HEIGHT_BITS-1:0]  req_y1_i,
  input  logic [HEIGHT_BITS-1:0]  req_y2_i,
  input  logic [WIDTH_BITS-1:0]   req_rad_i,
  input  logic [2:0]              req_oct_i,
  input  logic [CHANNEL_BITS-1:0] req_r_i,
  input  logic [CHANNEL_BITS-1:0] req_g_i,
  input  logic [CHANNEL_BITS-1:0] req_b_i,
  input  logic                    shadow_inv_i,
  output logic [3:0]              opcode_o,
  output logic [27:0]             parameters_o,
  output logic                    command_o,
  input  logic                    cmd_ready_i,
  output logic                    busy_o,
  output logic                    err_o
);
  localparam int W = WIDTH_BITS;
  localparam int H = HEIGHT_BITS;
  localparam int C = CHANNEL_BITS;

  typedef enum logic [2:0] {S_IDLE, S_XY1, S_XY2, S_RAD, S_DRAW} state_t;

  state_t         state_q, state_d;
  // captured request
  logic [3:0]     op_q;
  logic [W-1:0]   x1_q, x2_q, rad_q;
  logic [H-1:0]   y1_q, y2_q;
  logic [2:0]     oct_q;
  logic [C-1:0]   r_q, g_q, b_q;
  // shadows of what the decoder currently holds
  logic [W-1:0]   sh_x1_q, sh_x2_q, sh_rad_q;
  logic [H-1:0]   sh_y1_q, sh_y2_q;
  logic           xy1_v_q, xy2_v_q, rad_v_q;
  // registered command outputs
  logic [3:0]     opcode_q, opcode_d;
  logic [27:0]    params_q, params_d;
  logic           command_q, err_q, err_d;

  logic           accept, xfer;
  // request view for this cycle: the inputs on the accept edge, else the capture
  logic [3:0]     op_s;
  logic [W-1:0]   x1_s, x2_s, rad_s;
  logic [H-1:0]   y1_s, y2_s;
  logic [2:0]     oct_s;
  logic [C-1:0]   r_s, g_s, b_s;
  logic           is_line, is_circ, hit1, hit2, hitr;
  state_t         after_xy1;

  assign req_ready_o  = (state_q == S_IDLE);
  assign busy_o       = (state_q != S_IDLE);
  assign command_o    = command_q;
  assign opcode_o     = opcode_q;
  assign parameters_o = params_q;
  assign err_o        = err_q;

  assign accept = req_valid_i & req_ready_o;
  assign xfer   = command_q & cmd_ready_i;

  always_comb begin
    op_s  = accept ? req_opcode_i : op_q;
    x1_s  = accept ? req_x1_i     : x1_q;
    y1_s  = accept ? req_y1_i     : y1_q;
    x2_s  = accept ? req_x2_i     : x2_q;
    y2_s  = accept ? req_y2_i     : y2_q;
    rad_s = accept ? req_rad_i    : rad_q;
    oct_s = accept ? req_oct_i    : oct_q;
    r_s   = accept ? req_r_i      : r_q;
    g_s   = accept ? req_g_i      : g_q;
    b_s   = accept ? req_b_i      : b_q;

    is_line = (op_s[3:1] == 3'b010);   // 4, 5
    is_circ = (op_s[3:1] == 3'b011);   // 6, 7
    hit1 = xy1_v_q && (sh_x1_q == x1_s) && (sh_y1_q == y1_s);
    hit2 = xy2_v_q && (sh_x2_q == x2_s) && (sh_y2_q == y2_s);
    hitr = rad_v_q && (sh_rad_q == rad_s);

    // step following XY1 (also used when XY1 itself is skipped)
    if (is_line) after_xy1 = hit2 ? S_DRAW : S_XY2;
    else         after_xy1 = hitr ? S_DRAW : S_RAD;

    state_d = state_q;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: if (accept) begin
        if (is_line || is_circ) state_d = hit1 ? after_xy1 : S_XY1;
        else                    err_d   = 1'b1;
      end
      S_XY1:         if (xfer) state_d = after_xy1;
      S_XY2, S_RAD:  if (xfer) state_d = S_DRAW;
      S_DRAW:        if (xfer) state_d = S_IDLE;
      default:       state_d = S_IDLE;
    endcase

    // Outputs are derived from the state being entered so they are registered
    // together with it and stay stable while backpressured.
    opcode_d = 4'd0;
    params_d = '0;
    case (state_d)
      S_XY1: begin
        opcode_d            = 4'd1;
        params_d[W-1:0]     = x1_s;
        params_d[W+H-1:W]   = y1_s;
      end
      S_XY2: begin
        opcode_d            = 4'd2;
        params_d[W-1:0]     = x2_s;
        params_d[W+H-1:W]   = y2_s;
      end
      S_RAD: begin
        opcode_d            = 4'd3;
        params_d[W-1:0]     = rad_s;
      end
      S_DRAW: begin
        opcode_d             = op_s;
        params_d[C-1:0]      = b_s;
        params_d[2*C-1:C]    = g_s;
        params_d[3*C-1:2*C]  = r_s;
        if (op_s == 4'd7) params_d[27:25] = oct_s;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      x1_q      <= '0;
      y1_q      <= '0;
      x2_q      <= '0;
      y2_q      <= '0;
      rad_q     <= '0;
      oct_q     <= '0;
      r_q       <= '0;
      g_q       <= '0;
      b_q       <= '0;
      sh_x1_q   <= '0;
      sh_y1_q   <= '0;
      sh_x2_q   <= '0;
      sh_y2_q   <= '0;
      sh_rad_q  <= '0;
      xy1_v_q   <= 1'b0;
      xy2_v_q   <= 1'b0;
      rad_v_q   <= 1'b0;
      opcode_q  <= '0;
      params_q  <= '0;
      command_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      params_q  <= params_d;
      command_q <= (state_d != S_IDLE);
      err_q     <= err_d;
      if (accept) begin
        op_q  <= req_opcode_i;
        x1_q  <= req_x1_i;
        y1_q  <= req_y1_i;
        x2_q  <= req_x2_i;
        y2_q  <= req_y2_i;
        rad_q <= req_rad_i;
        oct_q <= req_oct_i;
        r_q   <= req_r_i;
        g_q   <= req_g_i;
        b_q   <= req_b_i;
      end
      // shadow values follow completed set commands
      if (xfer && state_q == S_XY1) begin
        sh_x1_q <= x1_q;
        sh_y1_q <= y1_q;
      end
      if (xfer && state_q == S_XY2) begin
        sh_x2_q <= x2_q;
        sh_y2_q <= y2_q;
      end
      if (xfer && state_q == S_RAD) sh_rad_q <= rad_q;
      // invalidation overrides a simultaneous shadow write
      if (shadow_inv_i) begin
        xy1_v_q <= 1'b0;
        xy2_v_q <= 1'b0;
        rad_v_q <= 1'b0;
      end else if (xfer) begin
        if (state_q == S_XY1) xy1_v_q <= 1'b1;
        if (state_q == S_XY2) xy2_v_q <= 1'b1;
        if (state_q == S_RAD) rad_v_q <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_gpu_instruction_encoder.sv
module tb_gpu_instruction_encoder;
  localparam int W = 10;
  localparam int H = 9;
  localparam int C = 8;

  logic         clk = 1'b0;
  logic         n_rst;
  logic         req_valid_i;
  logic         req_ready_o;
  logic [3:0]   req_opcode_i;
  logic [W-1:0] req_x1_i, req_x2_i, req_rad_i;
  logic [H-1:0] req_y1_i, req_y2_i;
  logic [2:0]   req_oct_i;
  logic [C-1:0] req_r_i, req_g_i, req_b_i;
  logic         shadow_inv_i;
  logic [3:0]   opcode_o;
  logic [27:0]  parameters_o;
  logic         command_o;
  logic         cmd_ready_i;
  logic         busy_o;
  logic         err_o;

  gpu_instruction_encoder #(.WIDTH_BITS(W), .HEIGHT_BITS(H), .CHANNEL_BITS(C)) dut (
    .clk(clk), .n_rst(n_rst),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_opcode_i(req_opcode_i),
    .req_x1_i(req_x1_i), .req_x2_i(req_x2_i),
    .req_y1_i(req_y1_i), .req_y2_i(req_y2_i),
    .req_rad_i(req_rad_i), .req_oct_i(req_oct_i),
    .req_r_i(req_r_i), .req_g_i(req_g_i), .req_b_i(req_b_i),
    .shadow_inv_i(shadow_inv_i),
    .opcode_o(opcode_o), .parameters_o(parameters_o), .command_o(command_o),
    .cmd_ready_i(cmd_ready_i), .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_err;
    logic [3:0]  op;
    logic [27:0] prm;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  bit   rand_mode = 0;
  bit   ready_force = 1;

  // reference model: what the decoder is believed to hold
  bit         m_v1, m_v2, m_vr;
  int         m_x1, m_y1, m_x2, m_y2, m_rad;

  function automatic void push_cmd(input int op, input int prm);
    exp_t e;
    e.is_err = 0;
    e.op     = 4'(op);
    e.prm    = 28'(prm);
    q.push_back(e);
  endfunction

  // Expected command list for one request, computed from the protocol rules.
  function automatic void model_req(input int op, input int x1, input int y1,
                                    input int x2, input int y2, input int rad,
                                    input int oct, input int r, input int g, input int b);
    exp_t e;
    if (op < 4 || op > 7) begin
      e.is_err = 1;
      e.op     = 4'd0;
      e.prm    = 28'd0;
      q.push_back(e);
      return;
    end
    if (!(m_v1 && m_x1 == x1 && m_y1 == y1)) begin
      push_cmd(1, x1 + y1 * (1 << W));
      m_v1 = 1; m_x1 = x1; m_y1 = y1;
    end
    if (op <= 5) begin
      if (!(m_v2 && m_x2 == x2 && m_y2 == y2)) begin
        push_cmd(2, x2 + y2 * (1 << W));
        m_v2 = 1; m_x2 = x2; m_y2 = y2;
      end
    end else begin
      if (!(m_vr && m_rad == rad)) begin
        push_cmd(3, rad);
        m_vr = 1; m_rad = rad;
      end
    end
    push_cmd(op, b + g * 256 + r * 65536 + ((op == 7) ? oct * (1 << 25) : 0));
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // cmd_ready driver: random during the random phase, else forced
  initial begin
    cmd_ready_i = 1'b1;
    forever begin
      @(posedge clk);
      #2 cmd_ready_i = rand_mode ? 1'($urandom_range(0, 1)) : ready_force;
    end
  end

  // monitor: scoreboard pops plus hold-under-backpressure checks
  initial begin
    bit          hold_pend;
    logic [3:0]  hold_op;
    logic [27:0] hold_prm;
    exp_t        e;
    hold_pend = 0;
    hold_op   = '0;
    hold_prm  = '0;
    forever begin
      @(negedge clk);
      if (!n_rst) begin
        hold_pend = 0;
      end else begin
        if (hold_pend && command_o) begin
          checks++;
          if (opcode_o !== hold_op || parameters_o !== hold_prm) begin
            failures++;
            $display("FAIL hold: got op=%0d prm=0x%0h expected op=%0d prm=0x%0h",
                     opcode_o, parameters_o, hold_op, hold_prm);
          end
        end
        hold_pend = command_o && !cmd_ready_i;
        hold_op   = opcode_o;
        hold_prm  = parameters_o;
        if (err_o) begin
          checks++;
          if (q.size() == 0 || !q[0].is_err) begin
            failures++;
            $display("FAIL err_pulse: got err_o=1 expected no error");
          end else begin
            void'(q.pop_front());
            $display("t=%0t err pulse", $time);
          end
        end
        if (command_o && cmd_ready_i) begin
          checks++;
          if (q.size() == 0) begin
            failures++;
            $display("FAIL cmd_unexpected: got op=%0d prm=0x%0h expected none", opcode_o, parameters_o);
          end else begin
            e = q.pop_front();
            if (e.is_err || opcode_o !== e.op || parameters_o !== e.prm) begin
              failures++;
              $display("FAIL cmd: got op=%0d prm=0x%0h expected op=%0d prm=0x%0h err=%0d",
                       opcode_o, parameters_o, e.op, e.prm, e.is_err);
            end else begin
              $display("t=%0t cmd op=%0d prm=0x%07h", $time, opcode_o, parameters_o);
            end
          end
        end
      end
    end
  end

  task automatic send(input int op, input int x1, input int y1, input int x2, input int y2,
                      input int rad, input int oct, input int r, input int g, input int b);
    int n;
    @(posedge clk);
    #1;
    req_opcode_i = 4'(op);
    req_x1_i = W'(x1); req_y1_i = H'(y1);
    req_x2_i = W'(x2); req_y2_i = H'(y2);
    req_rad_i = W'(rad); req_oct_i = 3'(oct);
    req_r_i = C'(r); req_g_i = C'(g); req_b_i = C'(b);
    req_valid_i = 1'b1;
    n = 0;
    while (1) begin
      @(negedge clk);
      if (req_ready_o) break;
      n++;
      if (n > 300) begin
        checks++;
        failures++;
        $display("FAIL accept_timeout: got req_ready_o=0 expected 1 within 300 cycles");
        break;
      end
    end
    @(posedge clk);
    #1 req_valid_i = 1'b0;
    // request was accepted on the edge above; wiggle inputs to prove they are ignored
    req_x1_i = W'($urandom); req_rad_i = W'($urandom); req_r_i = C'($urandom);
    model_req(op, x1, y1, x2, y2, rad, oct, r, g, b);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (1) begin
      @(negedge clk);
      if (!busy_o && q.size() == 0) break;
      n++;
      if (n > 500) break;
    end
    check("drain_queue", q.size(), 0);
    check("idle_ready", req_ready_o, 1);
    check("idle_command", command_o, 0);
  endtask

  task automatic pulse_inv();
    @(posedge clk);
    #1 shadow_inv_i = 1'b1;
    @(posedge clk);
    #1 shadow_inv_i = 1'b0;
    m_v1 = 0; m_v2 = 0; m_vr = 0;
  endtask

  initial begin
    n_rst = 1'b0;
    req_valid_i = 0; req_opcode_i = 0;
    req_x1_i = 0; req_x2_i = 0; req_y1_i = 0; req_y2_i = 0;
    req_rad_i = 0; req_oct_i = 0; req_r_i = 0; req_g_i = 0; req_b_i = 0;
    shadow_inv_i = 0;
    m_v1 = 0; m_v2 = 0; m_vr = 0;
    m_x1 = 0; m_y1 = 0; m_x2 = 0; m_y2 = 0; m_rad = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", req_ready_o, 1);
    check("rst_command", command_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_err", err_o, 0);
    check("rst_opcode", opcode_o, 0);
    check("rst_params", parameters_o, 0);
    n_rst = 1'b1;

    // line after reset: full sequence op1, op2, op4
    send(4, 5, 7, 100, 200, 0, 0, 'h11, 'h22, 'h33);
    check("line_first_op", opcode_o, 1);
    check("line_first_prm", parameters_o, 32'h0001C05);
    wait_idle();

    // identical line: both set commands hit, draw one cycle after accept
    send(4, 5, 7, 100, 200, 0, 0, 'h11, 'h22, 'h33);
    check("repeat_cmd", command_o, 1);
    check("repeat_op", opcode_o, 4);
    wait_idle();

    // arc: XY1 hits, radius then draw with octant
    send(7, 5, 7, 100, 200, 50, 5, 'hFF, 0, 1);
    wait_idle();

    // backpressure while XY2 is offered
    ready_force = 0;
    send(5, 5, 7, 300, 100, 0, 0, 1, 2, 3);
    repeat (4) @(posedge clk);
    #1;
    check("bp_op", opcode_o, 2);
    check("bp_prm", parameters_o, 300 + 100 * 1024);
    check("bp_busy", busy_o, 1);
    ready_force = 1;
    wait_idle();

    // invalidate shadows, circle reissues XY1 and RAD
    pulse_inv();
    send(6, 5, 7, 0, 0, 50, 0, 9, 8, 7);
    wait_idle();

    // unsupported opcode
    send(9, 1, 2, 3, 4, 5, 6, 7, 8, 9);
    check("err_pulse_hi", err_o, 1);
    check("err_no_cmd", command_o, 0);
    check("err_ready", req_ready_o, 1);
    @(posedge clk);
    #1 check("err_pulse_lo", err_o, 0);
    wait_idle();

    // reset while RAD is stalled
    ready_force = 0;
    send(6, 5, 7, 0, 0, 60, 0, 9, 8, 7);
    @(posedge clk);
    #1 check("rad_stall_op", opcode_o, 3);
    n_rst = 1'b0;
    #1;
    check("midrst_command", command_o, 0);
    check("midrst_busy", busy_o, 0);
    check("midrst_ready", req_ready_o, 1);
    q.delete();
    m_v1 = 0; m_v2 = 0; m_vr = 0;
    @(posedge clk);
    #1 n_rst = 1'b1;
    ready_force = 1;
    send(6, 5, 7, 0, 0, 60, 0, 9, 8, 7);
    check("post_rst_op", opcode_o, 1);
    wait_idle();

    // randomized traffic, small value sets so shadow hits occur
    rand_mode = 1;
    for (int i = 0; i < 150; i++) begin
      int op;
      op = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(4, 7));
      if ($urandom_range(0, 9) == 0) begin
        wait_idle();
        pulse_inv();
      end
      send(op, $urandom_range(0, 2), $urandom_range(0, 1) * 511, $urandom_range(1022, 1023),
           $urandom_range(0, 2), $urandom_range(0, 2) * 500, $urandom_range(0, 7),
           $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
    end
    rand_mode = 0;
    ready_force = 1;
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
